// File: rtl/out_layer_mac.sv
// ============================================================================
// out_layer_mac
// ----------------------------------------------------------------------------
// Output-layer dense engine. Computes N_OUT neuron outputs in parallel:
//
//   act[c] = relu?( sat( round( sum_k in[k]*w[c][k] + (bias[c] << FRAC) ) ) )
//
// All operands are DW-bit signed fixed point with FRAC fractional bits. The
// hidden activations and the weight/bias rows are read through synchronous
// read ports that share one address (o_rd_addr). Index N_IN of the weight
// memory holds the per-channel bias.
//
// Ports
//   i_clk         : sole clock, rising edge
//   i_rst         : synchronous, active-high reset
//   i_start       : request one computation (sampled only in IDLE)
//   i_relu_en     : clamp negative results to zero (captured with i_start)
//   o_rd_addr     : shared read index for both memories
//   i_in_rd_data  : hidden activation for the address presented last cycle
//   i_w_rd_data   : channel c weight (or bias at index N_IN) at [c*DW +: DW]
//   o_busy        : high from start acceptance until the done edge
//   o_done        : one-cycle pulse, o_act_out / o_sat valid
//   o_act_out     : channel c result at [c*DW +: DW], held until next done
//   o_sat         : per-channel saturation flag, updated with o_act_out
//   o_dbg_state   : current FSM state (IDLE=0, FETCH=1, BIAS=2, FINISH=3)
//
// Handshake: i_start is a level sampled only while the FSM is in IDLE; a
// start seen while busy is dropped, not queued. Acceptance raises o_busy on
// the same edge. Exactly N_IN+3 edges later o_done pulses for one cycle
// with o_busy low, and the FSM is back in IDLE during that cycle, so a start
// held high through the done cycle is accepted on the following edge.
// Reset in any state aborts the computation without a done pulse.
//
// Timing (start accepted at edge 0):
//   edge k (k=0..N_IN)  : o_rd_addr = k
//   edge k+2            : index k product accumulated
//   edge N_IN+2         : bias accumulated
//   edge N_IN+3         : o_act_out/o_sat registered, o_done = 1
// ============================================================================
module out_layer_mac #(
    parameter int N_IN  = 10,
    parameter int N_OUT = 2,
    parameter int DW    = 16,
    parameter int FRAC  = 8,
    parameter int ACC_W = 40,
    parameter int AW    = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic                  i_relu_en,
    output logic [AW-1:0]         o_rd_addr,
    input  logic [DW-1:0]         i_in_rd_data,
    input  logic [N_OUT*DW-1:0]   i_w_rd_data,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [N_OUT*DW-1:0]   o_act_out,
    output logic [N_OUT-1:0]      o_sat,
    output logic [1:0]            o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_BIAS   = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    // Last address issued: the bias row.
    localparam logic [AW-1:0] LAST_ADDR = AW'(N_IN);

    // Rounding constant 2^(FRAC-1) for round-half-up.
    localparam logic [ACC_W-1:0] HALF = ACC_W'(1) << (FRAC - 1);

    // Output range limits expressed at accumulator width for comparison.
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t              r_state;
    logic [ACC_W-1:0]    r_acc [N_OUT];
    logic                r_relu;
    // High when i_in_rd_data/i_w_rd_data in this cycle belong to a data
    // index (< N_IN) issued on the previous cycle.
    logic                r_dvld;

    // ------------------------------------------------------------------------
    // Per-channel datapath
    // ------------------------------------------------------------------------
    logic signed [2*DW-1:0]  w_act_ext;
    logic [N_OUT*ACC_W-1:0]  w_prod_bus;
    logic [N_OUT*ACC_W-1:0]  w_bias_bus;
    logic [N_OUT*DW-1:0]     w_res_bus;
    logic [N_OUT-1:0]        w_clamp_bus;

    // Sign-extending both factors to 2*DW keeps the product exact in the
    // low 2*DW bits without relying on mixed-width multiply rules.
    assign w_act_ext = {{DW{i_in_rd_data[DW-1]}}, i_in_rd_data};

    for (genvar c = 0; c < N_OUT; c++) begin : g_ch
        logic [DW-1:0]           w_wt;
        logic signed [2*DW-1:0]  w_wt_ext;
        logic signed [2*DW-1:0]  w_prod;
        logic [ACC_W-1:0]        w_sum;
        logic signed [ACC_W-1:0] w_shift;
        logic [DW-1:0]           w_res;
        logic                    w_clamp;

        assign w_wt     = i_w_rd_data[c*DW +: DW];
        assign w_wt_ext = {{DW{w_wt[DW-1]}}, w_wt};
        assign w_prod   = w_act_ext * w_wt_ext;

        assign w_prod_bus[c*ACC_W +: ACC_W] =
            {{(ACC_W-2*DW){w_prod[2*DW-1]}}, w_prod};

        // Bias is aligned to the product scale (2*FRAC fractional bits) by
        // shifting it up by FRAC.
        assign w_bias_bus[c*ACC_W +: ACC_W] =
            {{(ACC_W-DW-FRAC){w_wt[DW-1]}}, w_wt, {FRAC{1'b0}}};

        // Round half up, then drop FRAC fractional bits arithmetically.
        assign w_sum   = r_acc[c] + HALF;
        assign w_shift = $signed(w_sum) >>> FRAC;

        always_comb begin
            w_res   = w_shift[DW-1:0];
            w_clamp = 1'b0;
            if (w_shift > SAT_MAX) begin
                w_res   = SAT_MAX[DW-1:0];
                w_clamp = 1'b1;
            end else if (w_shift < SAT_MIN) begin
                w_res   = SAT_MIN[DW-1:0];
                w_clamp = 1'b1;
            end
            // ReLU applies after saturation and leaves the flag alone.
            if (r_relu && w_res[DW-1]) begin
                w_res = '0;
            end
        end

        assign w_res_bus[c*DW +: DW] = w_res;
        assign w_clamp_bus[c]        = w_clamp;
    end

    // ------------------------------------------------------------------------
    // Control FSM and registers
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_relu    <= 1'b0;
            r_dvld    <= 1'b0;
            o_rd_addr <= '0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_act_out <= '0;
            o_sat     <= '0;
            for (int c = 0; c < N_OUT; c++) begin
                r_acc[c] <= '0;
            end
        end else begin
            o_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        for (int c = 0; c < N_OUT; c++) begin
                            r_acc[c] <= '0;
                        end
                        o_rd_addr <= '0;
                        r_relu    <= i_relu_en;
                        r_dvld    <= 1'b0;
                        o_busy    <= 1'b1;
                        r_state   <= S_FETCH;
                    end
                end

                S_FETCH: begin
                    if (r_dvld) begin
                        for (int c = 0; c < N_OUT; c++) begin
                            r_acc[c] <= r_acc[c] + w_prod_bus[c*ACC_W +: ACC_W];
                        end
                    end
                    // Once the bias address has been presented, the next
                    // cycle carries the bias row, handled in BIAS.
                    if (o_rd_addr == LAST_ADDR) begin
                        r_dvld  <= 1'b0;
                        r_state <= S_BIAS;
                    end else begin
                        r_dvld    <= 1'b1;
                        o_rd_addr <= o_rd_addr + AW'(1);
                    end
                end

                S_BIAS: begin
                    for (int c = 0; c < N_OUT; c++) begin
                        r_acc[c] <= r_acc[c] + w_bias_bus[c*ACC_W +: ACC_W];
                    end
                    r_state <= S_FINISH;
                end

                S_FINISH: begin
                    o_act_out <= w_res_bus;
                    o_sat     <= w_clamp_bus;
                    o_done    <= 1'b1;
                    o_busy    <= 1'b0;
                    r_state   <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_out_layer_mac.sv
// ============================================================================
// tb_out_layer_mac
// ----------------------------------------------------------------------------
// Self-checking bench for out_layer_mac at default parameters. A small memory
// model answers the shared read address with one cycle of latency. Expected
// results come from a reference function that evaluates the dot products
// directly with 64-bit integer arithmetic.
// ============================================================================
module tb_out_layer_mac;

    localparam int N_IN  = 10;
    localparam int N_OUT = 2;
    localparam int DW    = 16;
    localparam int FRAC  = 8;
    localparam int ACC_W = 40;
    localparam int AW    = 4;
    localparam int LAT   = N_IN + 3;

    // ------------------------------------------------------------------------
    // Clock / reset / DUT
    // ------------------------------------------------------------------------
    logic                clk;
    logic                rst;
    logic                start;
    logic                relu_en;
    logic [AW-1:0]       rd_addr;
    logic [DW-1:0]       in_rd_data;
    logic [N_OUT*DW-1:0] w_rd_data;
    logic                busy;
    logic                done;
    logic [N_OUT*DW-1:0] act_out;
    logic [N_OUT-1:0]    sat;
    logic [1:0]          dbg_state;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    out_layer_mac #(
        .N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .FRAC(FRAC), .ACC_W(ACC_W), .AW(AW)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_relu_en    (relu_en),
        .o_rd_addr    (rd_addr),
        .i_in_rd_data (in_rd_data),
        .i_w_rd_data  (w_rd_data),
        .o_busy       (busy),
        .o_done       (done),
        .o_act_out    (act_out),
        .o_sat        (sat),
        .o_dbg_state  (dbg_state)
    );

    // ------------------------------------------------------------------------
    // Memory model: one-cycle synchronous read
    // ------------------------------------------------------------------------
    logic [DW-1:0] in_mem [N_IN];
    logic [DW-1:0] w_mem  [N_OUT][N_IN+1];   // index N_IN = bias
    logic [AW-1:0] mem_addr_q;

    always @(posedge clk) mem_addr_q <= rd_addr;

    always_comb begin
        in_rd_data = '0;
        w_rd_data  = '0;
        if (int'(mem_addr_q) < N_IN) in_rd_data = in_mem[mem_addr_q];
        for (int c = 0; c < N_OUT; c++) begin
            if (int'(mem_addr_q) <= N_IN) w_rd_data[c*DW +: DW] = w_mem[c][mem_addr_q];
        end
    end

    // ------------------------------------------------------------------------
    // Scoreboard counters and check helper
    // ------------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    // ------------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------------
    function automatic void model(input logic relu,
                                  output logic [N_OUT*DW-1:0] act,
                                  output logic [N_OUT-1:0] s);
        longint acc, r, maxv, minv;
        maxv = (longint'(1) <<< (DW-1)) - 1;
        minv = -(longint'(1) <<< (DW-1));
        act = '0;
        s   = '0;
        for (int c = 0; c < N_OUT; c++) begin
            acc = 0;
            for (int i = 0; i < N_IN; i++)
                acc += longint'($signed(in_mem[i])) * longint'($signed(w_mem[c][i]));
            acc += longint'($signed(w_mem[c][N_IN])) * (longint'(1) <<< FRAC);
            r = (acc + (longint'(1) <<< (FRAC-1))) >>> FRAC;
            if (r > maxv) begin
                r = maxv; s[c] = 1'b1;
            end else if (r < minv) begin
                r = minv; s[c] = 1'b1;
            end
            if (relu && r < 0) r = 0;
            act[c*DW +: DW] = r[DW-1:0];
        end
    endfunction

    // ------------------------------------------------------------------------
    // Directed vectors
    // ------------------------------------------------------------------------
    typedef struct {
        logic [DW-1:0]       in_v;
        logic [DW-1:0]       w0, w1, b0, b1;
        bit                  first_only;   // only in[0] nonzero
        bit                  relu;
        logic [N_OUT*DW-1:0] exp_act;      // {ch1, ch0}
        logic [N_OUT-1:0]    exp_sat;
    } vec_t;

    vec_t vecs [8];

    task automatic load_vec(input vec_t v);
        for (int i = 0; i < N_IN; i++) begin
            in_mem[i]   = (v.first_only && i != 0) ? '0 : v.in_v;
            w_mem[0][i] = v.w0;
            w_mem[1][i] = v.w1;
        end
        w_mem[0][N_IN] = v.b0;
        w_mem[1][N_IN] = v.b1;
    endtask

    // ------------------------------------------------------------------------
    // Driver: one computation, returns cycles from accept edge to done
    // ------------------------------------------------------------------------
    task automatic run_op(input logic relu, input string tag, output int lat);
        @(negedge clk);
        start   = 1'b1;
        relu_en = relu;
        @(negedge clk);             // edge 0 has accepted the start
        start   = 1'b0;
        relu_en = 1'b0;
        check({tag, "_busy_accept"}, 64'(busy), 64'd1);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                break;
            end
        end
        check({tag, "_busy_done"}, 64'(busy), 64'd0);
    endtask

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    initial begin
        logic [N_OUT*DW-1:0] e_act;
        logic [N_OUT-1:0]    e_sat;
        int lat, n_done, first_at, second_at;

        start   = 1'b0;
        relu_en = 1'b0;
        rst     = 1'b1;
        for (int i = 0; i < N_IN; i++) in_mem[i] = '0;
        for (int c = 0; c < N_OUT; c++)
            for (int i = 0; i <= N_IN; i++) w_mem[c][i] = '0;

        vecs[0] = '{16'h0080, 16'h0100, 16'h0100, 16'h0000, 16'h0000, 0, 0, 32'h0500_0500, 2'b00};
        vecs[1] = '{16'h0020, 16'h0100, 16'h0100, 16'hFD00, 16'h0000, 0, 0, 32'h0140_FE40, 2'b00};
        vecs[2] = '{16'h0020, 16'h0100, 16'h0100, 16'hFD00, 16'h0000, 0, 1, 32'h0140_0000, 2'b00};
        vecs[3] = '{16'h7F00, 16'h7F00, 16'h7F00, 16'h0000, 16'h0000, 0, 0, 32'h7FFF_7FFF, 2'b11};
        vecs[4] = '{16'h7F00, 16'h8100, 16'h8100, 16'h0000, 16'h0000, 0, 0, 32'h8000_8000, 2'b11};
        vecs[5] = '{16'h0001, 16'h0080, 16'h0080, 16'h0000, 16'h0000, 1, 0, 32'h0001_0001, 2'b00};
        vecs[6] = '{16'h0001, 16'hFF80, 16'hFF80, 16'h0000, 16'h0000, 1, 0, 32'h0000_0000, 2'b00};
        vecs[7] = '{16'h0100, 16'h0100, 16'hFF00, 16'h0100, 16'h0000, 0, 1, 32'h0000_0B00, 2'b00};

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_busy",    64'(busy),    64'd0);
        check("rst_done",    64'(done),    64'd0);
        check("rst_act",     64'(act_out), 64'd0);
        check("rst_sat",     64'(sat),     64'd0);
        check("rst_rd_addr", 64'(rd_addr), 64'd0);
        check("rst_state",   64'(dbg_state), 64'd0);

        // Directed table
        for (int v = 0; v < 8; v++) begin
            load_vec(vecs[v]);
            run_op(vecs[v].relu, $sformatf("vec%0d", v), lat);
            check($sformatf("vec%0d_latency", v), 64'(lat), 64'(LAT));
            check($sformatf("vec%0d_act", v), 64'(act_out), 64'(vecs[v].exp_act));
            check($sformatf("vec%0d_sat", v), 64'(sat), 64'(vecs[v].exp_sat));
        end

        // Randomized against the reference model
        for (int r = 0; r < 24; r++) begin
            for (int i = 0; i < N_IN; i++) begin
                case (r % 3)
                    0: in_mem[i] = DW'($urandom_range(0, 65535));
                    1: in_mem[i] = DW'($urandom_range(0, 1024) - 512);
                    default: in_mem[i] = DW'($urandom_range(16'h4000, 16'h7FFF));
                endcase
            end
            for (int c = 0; c < N_OUT; c++) begin
                for (int i = 0; i <= N_IN; i++) begin
                    case (r % 3)
                        0: w_mem[c][i] = DW'($urandom_range(0, 65535));
                        1: w_mem[c][i] = DW'($urandom_range(0, 1024) - 512);
                        default: w_mem[c][i] = DW'($urandom_range(0, 65535));
                    endcase
                end
            end
            relu_en = 1'b0;
            model(1'($urandom_range(0, 1)), e_act, e_sat);
            // Reuse the relu bit that the model was evaluated with.
            begin
                logic rl;
                rl = 1'($urandom_range(0, 1));
                model(rl, e_act, e_sat);
                run_op(rl, $sformatf("rnd%0d", r), lat);
            end
            check($sformatf("rnd%0d_latency", r), 64'(lat), 64'(LAT));
            check($sformatf("rnd%0d_act", r), 64'(act_out), 64'(e_act));
            check($sformatf("rnd%0d_sat", r), 64'(sat), 64'(e_sat));
        end

        // Start re-pulsed at cycle 4 is ignored: exactly one done at LAT
        load_vec(vecs[0]);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        n_done = 0; first_at = -1;
        for (int i = 1; i <= 40; i++) begin
            start = (i == 4);
            @(negedge clk);
            if (done) begin
                n_done++;
                if (first_at < 0) first_at = i;
            end
        end
        start = 1'b0;
        check("ignore_first_done", 64'(first_at), 64'(LAT));
        check("ignore_done_count", 64'(n_done), 64'd1);

        // Start held high through the done cycle: re-accepted on the edge
        // after done, second result LAT cycles after that edge
        load_vec(vecs[1]);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        n_done = 0; first_at = -1; second_at = -1;
        for (int i = 1; i <= 45; i++) begin
            start = (i <= LAT + 1);
            @(negedge clk);
            if (done) begin
                n_done++;
                if (first_at < 0) first_at = i;
                else if (second_at < 0) begin
                    second_at = i;
                    check("b2b_second_act", 64'(act_out), 64'(vecs[1].exp_act));
                end
            end
        end
        start = 1'b0;
        check("b2b_first_done",  64'(first_at),  64'(LAT));
        check("b2b_second_done", 64'(second_at), 64'(2*LAT + 1));
        check("b2b_done_count",  64'(n_done),    64'd2);

        // Reset at cycle 5 of a computation aborts it with no done
        load_vec(vecs[3]);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);     // now after edge 4
        rst = 1'b1;
        @(negedge clk);                // edge 5 applied reset
        rst = 1'b0;
        check("abort_busy",    64'(busy),    64'd0);
        check("abort_act",     64'(act_out), 64'd0);
        check("abort_sat",     64'(sat),     64'd0);
        check("abort_done",    64'(done),    64'd0);
        check("abort_rd_addr", 64'(rd_addr), 64'd0);
        n_done = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("abort_no_done", 64'(n_done), 64'd0);

        // Fresh computation after abort
        load_vec(vecs[1]);
        run_op(1'b0, "post_abort", lat);
        check("post_abort_latency", 64'(lat), 64'(LAT));
        check("post_abort_act", 64'(act_out), 64'(vecs[1].exp_act));
        check("post_abort_sat", 64'(sat), 64'(vecs[1].exp_sat));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
